// File: rtl/mm_pkg.sv
// Shared constants and types for the memory mapper: register offsets, control bits,
// page geometry and the page-table entry type.
package mm_pkg;
  localparam int CPU_BITS   = 16;
  localparam int PAGE_BITS  = 12;
  localparam int IDX_BITS   = CPU_BITS - PAGE_BITS;
  localparam int NUM_PAGES  = 1 << IDX_BITS;
  localparam int PHYS_BITS  = 24;
  localparam int ENTRY_BITS = PHYS_BITS - PAGE_BITS;

  localparam logic [1:0] MM_IDX  = 2'd0;
  localparam logic [1:0] MM_LO   = 2'd1;
  localparam logic [1:0] MM_HI   = 2'd2;
  localparam logic [1:0] MM_STAT = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 7;

  typedef logic [ENTRY_BITS-1:0] mm_entry_t;

  function automatic logic [7:0] status_byte(input logic [IDX_BITS-1:0] idx,
                                             input logic pending,
                                             input logic enable);
    return {idx, 2'b00, pending, enable};
  endfunction
endpackage

// File: rtl/mm_table.sv
// Page table: 16x12 register file, identity on reset/clear, one write port,
// two combinational read ports (bus index, translation page); writes visible next cycle.
module mm_table
  import mm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] waddr_i,
  input  mm_entry_t           wdata_i,
  input  logic [IDX_BITS-1:0] bus_idx_i,
  output mm_entry_t           bus_entry_o,
  input  logic [IDX_BITS-1:0] xl_page_i,
  output mm_entry_t           xl_entry_o
);
  mm_entry_t entry_q [NUM_PAGES];

  // Clear shares the reset path so the whole table snaps back to identity in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int i = 0; i < NUM_PAGES; i++) begin
        entry_q[i] <= mm_entry_t'(i);
      end
    end else if (we_i) begin
      entry_q[waddr_i] <= wdata_i;
    end
  end

  assign bus_entry_o = entry_q[bus_idx_i];
  assign xl_entry_o  = entry_q[xl_page_i];
endmodule

// File: rtl/memory_mapper.sv
// Memory mapper bus responder: control/window registers, staged entry writes, 1-cycle
// registered read data, combinational address translation; no backpressure (bus is always ready).
module memory_mapper
  import mm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CPU_BITS-1:0]  addr,
  input  logic [7:0]           data_in,
  input  logic                 we,
  input  logic                 mm_cs1,
  input  logic                 mm_cs2,
  output logic [7:0]           data_out,
  output logic [PHYS_BITS-1:0] phys_addr
);
  logic [IDX_BITS-1:0] index_q, index_d;
  logic [7:0]          stage_lo_q, stage_lo_d;
  logic                pending_q, pending_d;
  logic                enable_q, enable_d;
  logic [7:0]          data_out_q, data_out_d;

  logic      ctrl_wr, win_wr, rd_vld;
  logic      tbl_we, tbl_clr;
  mm_entry_t tbl_wdata, bus_entry, xl_entry;
  logic [7:0] rd_mux;

  // Control select dominates: a simultaneous window access is dropped entirely.
  assign ctrl_wr = mm_cs2 & we;
  assign win_wr  = mm_cs1 & ~mm_cs2 & we;
  assign rd_vld  = (mm_cs1 | mm_cs2) & ~we;

  assign tbl_clr   = ctrl_wr & data_in[CTRL_CLR];
  assign tbl_we    = win_wr & (addr[1:0] == MM_HI);
  assign tbl_wdata = {data_in[3:0], (pending_q ? stage_lo_q : bus_entry[7:0])};

  mm_table u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (tbl_clr),
    .we_i        (tbl_we),
    .waddr_i     (index_q),
    .wdata_i     (tbl_wdata),
    .bus_idx_i   (index_q),
    .bus_entry_o (bus_entry),
    .xl_page_i   (addr[CPU_BITS-1:PAGE_BITS]),
    .xl_entry_o  (xl_entry)
  );

  always_comb begin
    rd_mux = 8'h00;
    if (mm_cs2) begin
      rd_mux = {7'b0, enable_q};
    end else begin
      case (addr[1:0])
        MM_IDX:  rd_mux = {4'h0, index_q};
        MM_LO:   rd_mux = bus_entry[7:0];
        MM_HI:   rd_mux = {4'h0, bus_entry[11:8]};
        default: rd_mux = status_byte(index_q, pending_q, enable_q);
      endcase
    end
  end

  always_comb begin
    index_d    = index_q;
    stage_lo_d = stage_lo_q;
    pending_d  = pending_q;
    enable_d   = enable_q;
    data_out_d = data_out_q;
    if (ctrl_wr) begin
      enable_d = data_in[CTRL_EN];
      if (data_in[CTRL_CLR]) begin
        pending_d = 1'b0;
        index_d   = '0;
      end
    end else if (win_wr) begin
      case (addr[1:0])
        MM_IDX: begin
          index_d   = data_in[IDX_BITS-1:0];
          pending_d = 1'b0;
        end
        MM_LO: begin
          stage_lo_d = data_in;
          pending_d  = 1'b1;
        end
        MM_HI: begin
          pending_d = 1'b0;
          index_d   = index_q + 1'b1;
        end
        default: ;
      endcase
    end
    if (rd_vld) begin
      data_out_d = rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index_q    <= '0;
      stage_lo_q <= 8'h00;
      pending_q  <= 1'b0;
      enable_q   <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      index_q    <= index_d;
      stage_lo_q <= stage_lo_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign phys_addr = enable_q ? {xl_entry, addr[PAGE_BITS-1:0]}
                              : {{(PHYS_BITS-CPU_BITS){1'b0}}, addr};
endmodule
